jtdd_scr_romrq: RTL and testbench

// - Responder side of the scroll-layer tile ROM port: accepts rom_addr, answers rom_data/rom_ok.
// - Turns address misses into SDRAM read requests and holds returned words in a small tag cache.
// - Sits between the scroll layer and the SDRAM controller slot; one instance per graphics ROM client.

---
 rtl/jtdd_romrq_pkg.sv | 27 ++
 rtl/jtdd_romrq_cache.sv | 114 +++++++++++
 rtl/jtdd_scr_romrq.sv | 128 ++++++++++++
 tb/tb_jtdd_scr_romrq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtdd_romrq_pkg.sv
// Shared definitions for the scroll-layer tile ROM requester.
//
// Contents:
//   romrq_state_e : request FSM states (idle, request outstanding, waiting for data)
//   NENTRY        : number of tag-cache entries
//   VW            : width of the victim pointer
//
// Build option: JTDD_SCRROM_CACHE2_EN selects a two-entry cache with round-robin
// replacement; without it the cache holds a single entry.
package jtdd_romrq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } romrq_state_e;

`ifdef JTDD_SCRROM_CACHE2_EN
    localparam int unsigned NENTRY = 2;
`else
    localparam int unsigned NENTRY = 1;
`endif

    // Kept at least one bit wide so the pointer register always exists.
    localparam int unsigned VW = (NENTRY > 1) ? $clog2(NENTRY) : 1;

endpackage

// File: rtl/jtdd_romrq_cache.sv
// Tag cache for the tile ROM requester: holds recently fetched SDRAM words
// keyed by client word address and answers lookups combinationally.
//
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset, clears tags, data, valid bits, pointer
//   flush_i       ROM download in progress: valid bits cleared, lookups forced to miss
//   fill_i        write one entry this cycle
//   fill_valid_i  valid bit stored with the filled entry
//   fill_tag_i    client address stored as the entry tag
//   fill_data_i   data word stored in the entry
//   lookup_i      client address to look up
//   hit_o         lookup_i matches a valid entry
//   data_o        data of the matching entry, zero on a miss
//
// Build option: JTDD_SCRROM_CACHE2_EN gives two entries with a victim pointer
// that toggles on every fill; otherwise every fill overwrites entry 0.
module jtdd_romrq_cache
    import jtdd_romrq_pkg::*;
#(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          fill_i,
    input  logic          fill_valid_i,
    input  logic [AW-1:0] fill_tag_i,
    input  logic [DW-1:0] fill_data_i,
    input  logic [AW-1:0] lookup_i,
    output logic          hit_o,
    output logic [DW-1:0] data_o
);

    logic [AW-1:0] tag_q   [NENTRY];
    logic [AW-1:0] tag_d   [NENTRY];
    logic [DW-1:0] data_q  [NENTRY];
    logic [DW-1:0] data_d  [NENTRY];
    logic          valid_q [NENTRY];
    logic          valid_d [NENTRY];
    logic [VW-1:0] vict_q;
    logic [VW-1:0] vict_d;

    // Victim selection
`ifdef JTDD_SCRROM_CACHE2_EN
    always_comb begin
        vict_d = vict_q;
        if (fill_i) begin
            vict_d = ~vict_q;
        end
    end
`else
    always_comb begin
        vict_d = '0;
    end
`endif

    // Entry update: fill the victim, then apply the download flush on top so
    // a fill landing during a download is stored invalid.
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        for (int i = 0; i < int'(NENTRY); i++) begin
            if (fill_i && (int'(vict_q) == i)) begin
                tag_d[i]   = fill_tag_i;
                data_d[i]  = fill_data_i;
                valid_d[i] = fill_valid_i;
            end
            if (flush_i) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NENTRY); i++) begin
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
            vict_q <= '0;
        end else begin
            for (int i = 0; i < int'(NENTRY); i++) begin
                tag_q[i]   <= tag_d[i];
                data_q[i]  <= data_d[i];
                valid_q[i] <= valid_d[i];
            end
            vict_q <= vict_d;
        end
    end

    // Lookup: first matching valid entry wins. Tags cannot normally repeat,
    // the priority only keeps the mux well defined.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int i = 0; i < int'(NENTRY); i++) begin
            if (!hit_o && valid_q[i] && (tag_q[i] == lookup_i)) begin
                hit_o  = 1'b1;
                data_o = data_q[i];
            end
        end
        // Valid bits only clear on the next edge; mask the hit in the
        // download cycle itself so stale data is never presented.
        if (flush_i) begin
            hit_o  = 1'b0;
            data_o = '0;
        end
    end

endmodule

// File: rtl/jtdd_scr_romrq.sv
// Responder side of the scroll-layer tile ROM port. Answers rom_addr_i from a
// small tag cache with zero latency; on a miss it issues one SDRAM read,
// waits for the word and fills the cache. Requests are never aborted: if the
// client moves on while a read is in flight, the read still completes and the
// new address is evaluated once the FSM is back in idle.
//
// Ports:
//   clk_i          system clock (single domain)
//   rst_i          synchronous active-high reset
//   downloading_i  ROM load in progress: no new requests, cache invalidated
//   rom_addr_i     client word address, may change every cycle
//   rom_data_o     word for rom_addr_i, valid while rom_ok_o is high
//   rom_ok_o       rom_addr_i hits a valid cache entry
//   sdram_addr_o   OFFSET + rom_addr_i (mod 2^SAW), captured at request start
//   sdram_req_o    read request, held until sdram_ack_i
//   sdram_ack_i    controller accepted the request (one-cycle pulse)
//   data_rdy_i     sdram_dout_i valid this cycle (one-cycle pulse)
//   sdram_dout_i   read data
//
// Build option: JTDD_SCRROM_CACHE2_EN enables the two-entry cache.
module jtdd_scr_romrq
    import jtdd_romrq_pkg::*;
#(
    parameter int unsigned    AW     = 17,
    parameter int unsigned    DW     = 16,
    parameter int unsigned    SAW    = 22,
    parameter logic [SAW-1:0] OFFSET = '0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           downloading_i,
    input  logic [AW-1:0]  rom_addr_i,
    output logic [DW-1:0]  rom_data_o,
    output logic           rom_ok_o,
    output logic [SAW-1:0] sdram_addr_o,
    output logic           sdram_req_o,
    input  logic           sdram_ack_i,
    input  logic           data_rdy_i,
    input  logic [DW-1:0]  sdram_dout_i
);

    romrq_state_e   state_q, state_d;
    logic [AW-1:0]  pend_q, pend_d;
    logic [SAW-1:0] saddr_q, saddr_d;
    logic           req_q, req_d;
    logic           fill;
    logic           hit;
    logic [SAW-1:0] addr_ext;

    // Zero-extend (or truncate) the client address to the SDRAM width; the
    // sum below then wraps naturally modulo 2^SAW.
    assign addr_ext = SAW'(rom_addr_i);

    jtdd_romrq_cache #(
        .AW (AW),
        .DW (DW)
    ) u_cache (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (downloading_i),
        .fill_i       (fill),
        .fill_valid_i (!downloading_i),
        .fill_tag_i   (pend_q),
        .fill_data_i  (sdram_dout_i),
        .lookup_i     (rom_addr_i),
        .hit_o        (hit),
        .data_o       (rom_data_o)
    );

    assign rom_ok_o     = hit;
    assign sdram_addr_o = saddr_q;
    assign sdram_req_o  = req_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        saddr_d = saddr_q;
        req_d   = req_q;
        fill    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!hit && !downloading_i) begin
                    pend_d  = rom_addr_i;
                    saddr_d = OFFSET + addr_ext;
                    req_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (sdram_ack_i) begin
                    req_d = 1'b0;
                    // Ack and data together: take the data in the same cycle.
                    if (data_rdy_i) begin
                        fill    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (data_rdy_i) begin
                    fill    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pend_q  <= '0;
            saddr_q <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            saddr_q <= saddr_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_jtdd_scr_romrq.sv
// Self-checking bench for jtdd_scr_romrq: directed scenarios followed by
// randomized traffic, all checked against a behavioural cache/request model.
module tb_jtdd_scr_romrq;

    localparam int          AW  = 17;
    localparam int          DW  = 16;
    localparam int          SAW = 22;
    localparam logic [21:0] OFF = 22'h3FF000;
`ifdef JTDD_SCRROM_CACHE2_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          downloading = 1'b0;
    logic [16:0]   rom_addr = '0;
    logic [15:0]   rom_data;
    logic          rom_ok;
    logic [21:0]   sdram_addr;
    logic          sdram_req;
    logic          sdram_ack = 1'b0;
    logic          data_rdy = 1'b0;
    logic [15:0]   sdram_dout = '0;

    int ncomp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    jtdd_scr_romrq #(
        .AW     (AW),
        .DW     (DW),
        .SAW    (SAW),
        .OFFSET (OFF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .downloading_i (downloading),
        .rom_addr_i    (rom_addr),
        .rom_data_o    (rom_data),
        .rom_ok_o      (rom_ok),
        .sdram_addr_o  (sdram_addr),
        .sdram_req_o   (sdram_req),
        .sdram_ack_i   (sdram_ack),
        .data_rdy_i    (data_rdy),
        .sdram_dout_i  (sdram_dout)
    );

    // Behavioural model: cache contents, replacement order, outstanding read.
    bit          m_valid [2];
    logic [16:0] m_tag   [2];
    logic [15:0] m_data  [2];
    int          m_vict  = 0;
    bit          m_busy  = 0;   // a read has been issued and not yet returned
    bit          m_reqp  = 0;   // that read has not been acknowledged yet
    logic [16:0] m_pend  = '0;
    logic [21:0] m_saddr = '0;
    bit          m_known = 0;

    function automatic bit m_hit(input logic [16:0] a, input bit dl, output logic [15:0] d);
        bit h = 0;
        d = '0;
        if (!dl) begin
            for (int i = 0; i < NE; i++) begin
                if (!h && m_valid[i] && m_tag[i] == a) begin
                    h = 1;
                    d = m_data[i];
                end
            end
        end
        return h;
    endfunction

    function automatic logic [21:0] sd_addr(input logic [16:0] a);
        return 22'((int'(OFF) + int'(a)) % (1 << SAW));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, compare against the model, then
    // advance the model with the same inputs at the rising edge.
    task automatic step(input logic [16:0] a, input bit dl, input bit ack, input bit rdy,
                        input logic [15:0] dout, input bit r);
        bit          h;
        logic [15:0] d;
        @(negedge clk);
        rom_addr    = a;
        downloading = dl;
        sdram_ack   = ack;
        data_rdy    = rdy;
        sdram_dout  = dout;
        rst         = r;
        #1;
        if (m_known) begin
            h = m_hit(a, dl, d);
            check("rom_ok", 32'(rom_ok), 32'(h));
            check("rom_data", 32'(rom_data), 32'(d));
            check("sdram_req", 32'(sdram_req), 32'(m_reqp));
            if (m_reqp) check("sdram_addr", 32'(sdram_addr), 32'(m_saddr));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0;
                m_tag[i]   = '0;
                m_data[i]  = '0;
            end
            m_vict  = 0;
            m_busy  = 0;
            m_reqp  = 0;
            m_pend  = '0;
            m_saddr = '0;
            m_known = 1;
        end else begin
            h = m_hit(a, dl, d);
            if (m_busy) begin
                bit take = 0;
                if (m_reqp) begin
                    if (ack) begin
                        m_reqp = 0;
                        take   = rdy;
                    end
                end else begin
                    take = rdy;
                end
                if (take) begin
                    m_valid[m_vict] = !dl;
                    m_tag[m_vict]   = m_pend;
                    m_data[m_vict]  = dout;
                    m_vict          = (m_vict + 1) % NE;
                    m_busy          = 0;
                end
            end else if (!h && !dl) begin
                m_busy  = 1;
                m_reqp  = 1;
                m_pend  = a;
                m_saddr = sd_addr(a);
            end
            if (dl) begin
                for (int i = 0; i < 2; i++) m_valid[i] = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [16:0] a);
        step(a, 0, 0, 0, 16'h0, 0);
    endtask

    task automatic ack(input logic [16:0] a);
        step(a, 0, 1, 0, 16'h0, 0);
    endtask

    task automatic rdy(input logic [16:0] a, input logic [15:0] d);
        step(a, 0, 0, 1, d, 0);
    endtask

    logic [16:0] pool [5];

    initial begin
        logic [16:0] ra;
        int          dl_cnt;
        pool[0] = 17'h00100;
        pool[1] = 17'h00101;
        pool[2] = 17'h00102;
        pool[3] = 17'h1FFFF;
        pool[4] = 17'h00000;

        // Reset state
        step(17'h0, 0, 0, 0, 16'h0, 1);
        step(17'h0, 0, 0, 0, 16'h0, 1);
        check("rst_rom_ok", 32'(rom_ok), 32'h0);
        check("rst_rom_data", 32'(rom_data), 32'h0);
        check("rst_sdram_req", 32'(sdram_req), 32'h0);
        check("rst_sdram_addr", 32'(sdram_addr), 32'h0);

        // First miss, ack, data
        idle(17'h00100);
        check("miss_req", 32'(sdram_req), 32'h1);
        check("miss_addr", 32'(sdram_addr), 32'h3FF100);
        ack(17'h00100);
        check("ack_drops_req", 32'(sdram_req), 32'h0);
        rdy(17'h00100, 16'hA55A);
        check("fill_ok", 32'(rom_ok), 32'h1);
        check("fill_data", 32'(rom_data), 32'hA55A);

        // Held address: no more requests
        for (int i = 0; i < 50; i++) begin
            idle(17'h00100);
            check("hold_no_req", 32'(sdram_req), 32'h0);
            check("hold_ok", 32'(rom_ok), 32'h1);
        end

        // Second address, then return to the first
        idle(17'h00101);
        check("req_101", 32'(sdram_addr), 32'h3FF101);
        ack(17'h00101);
        rdy(17'h00101, 16'h1111);
        check("data_101", 32'(rom_data), 32'h1111);
        idle(17'h00100);
`ifdef JTDD_SCRROM_CACHE2_EN
        check("c2_no_req", 32'(sdram_req), 32'h0);
        check("c2_ok", 32'(rom_ok), 32'h1);
        check("c2_data", 32'(rom_data), 32'hA55A);
`else
        check("c1_rereq", 32'(sdram_req), 32'h1);
        check("c1_miss", 32'(rom_ok), 32'h0);
        ack(17'h00100);
        rdy(17'h00100, 16'hA55A);
        check("c1_refill", 32'(rom_ok), 32'h1);
`endif

        // Address change while waiting for data
        idle(17'h00200);
        ack(17'h00200);
        idle(17'h00300);
        check("wait_no_req", 32'(sdram_req), 32'h0);
        rdy(17'h00300, 16'h2222);
        check("fill200_miss300", 32'(rom_ok), 32'h0);
        check("fill200_no_req", 32'(sdram_req), 32'h0);
        idle(17'h00300);
        check("req_300", 32'(sdram_req), 32'h1);
        check("addr_300", 32'(sdram_addr), 32'h3FF300);
        ack(17'h00300);
        rdy(17'h00300, 16'h3333);
        check("ok_300", 32'(rom_ok), 32'h1);
        check("data_300", 32'(rom_data), 32'h3333);
        for (int i = 0; i < 5; i++) begin
            idle(17'h00300);
            check("one_req_300", 32'(sdram_req), 32'h0);
        end

        // Download invalidates and blocks requests
        step(17'h00300, 1, 0, 0, 16'h0, 0);
        check("dl_ok", 32'(rom_ok), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(17'h00300, 1, 0, 0, 16'h0, 0);
            check("dl_no_req", 32'(sdram_req), 32'h0);
        end
        idle(17'h00300);
        check("dl_rereq", 32'(sdram_req), 32'h1);
        ack(17'h00300);
        rdy(17'h00300, 16'h4444);
        check("dl_refill", 32'(rom_data), 32'h4444);

        // SDRAM address wraps modulo 2^22
        idle(17'h1FFFF);
        check("wrap_addr", 32'(sdram_addr), 32'h01EFFF);
        ack(17'h1FFFF);
        rdy(17'h1FFFF, 16'h5A5A);
        check("wrap_data", 32'(rom_data), 32'h5A5A);

        // Reset while waiting for data; late data is ignored
        idle(17'h00400);
        ack(17'h00400);
        step(17'h00400, 0, 0, 0, 16'h0, 1);
        check("rstw_req", 32'(sdram_req), 32'h0);
        check("rstw_ok", 32'(rom_ok), 32'h0);
        rdy(17'h00400, 16'hBEEF);
        check("late_data_ok", 32'(rom_ok), 32'h0);

        // Randomized traffic against the model
        ra     = 17'h00100;
        dl_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            bit          dl, a, r, d;
            logic [15:0] dout;
            if (dl_cnt > 0) dl_cnt--;
            else if ($urandom_range(0, 59) == 0) dl_cnt = $urandom_range(1, 6);
            dl = (dl_cnt > 0);
            if ($urandom_range(0, 3) == 0) ra = pool[$urandom_range(0, 4)];
            a    = m_reqp && ($urandom_range(0, 1) == 1);
            d    = ($urandom_range(0, 2) == 0);
            r    = ($urandom_range(0, 199) == 0);
            dout = 16'($urandom);
            step(ra, dl, a, d, dout, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
